fifo_reader: RTL

- Read-side controller for the 10-bit FIFO (wr_enb/rd_enb/data_in/data_out/empty/alm_empty/alm_full interface).
- Pops words from the FIFO and presents them downstream on a valid/ready handshake.
- Absorbs the FIFO's 1-cycle read latency with a 2-entry skid buffer, so the stream runs at 1 word/clk with no loss under backpressure.
- Sits between the FIFO's data_out and the next pipeline stage (arbiter/demux).

---
 rtl/fifo_reader_pkg.sv | 15 +
 rtl/fifo_reader_skid.sv | 54 +++++
 rtl/fifo_reader.sv | 104 ++++++++++
 3 files changed

// File: rtl/fifo_reader_pkg.sv
// fifo_reader shared constants and FSM encoding.
// Optional stats counter: FIFO_READER_STATS_EN.
package fifo_reader_pkg;

  localparam int DATA_W     = 10;
  localparam int SKID_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } state_t;

endpackage

// File: rtl/fifo_reader_skid.sv
// Two-entry in-order skid buffer with a registered head.
// Absorbs the FIFO read latency under downstream backpressure.
module fifo_reader_skid
  import fifo_reader_pkg::*;
#(
  parameter int DW = fifo_reader_pkg::DATA_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          ready,
  output logic          pop,
  output logic          valid,
  output logic [DW-1:0] dout,
  output logic [1:0]    occ
);

  logic [DW-1:0] tail;

  assign valid = (occ != 2'd0);
  assign pop   = valid & ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ  <= 2'd0;
      dout <= '0;
      tail <= '0;
    end else begin
      unique case (1'b1)
        push & ~pop: begin
          if (occ == 2'd0) dout <= din;
          else             tail <= din;
          occ <= occ + 2'd1;
        end
        pop & ~push: begin
          dout <= tail;
          occ  <= occ - 2'd1;
        end
        push & pop: begin
          // Occupancy holds; the new word lands behind the survivor.
          if (occ == 2'd1) begin
            dout <= din;
          end else begin
            dout <= tail;
            tail <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_reader.sv
// FIFO read-side controller: issue FSM plus skid buffer.
// Optional stats counter: FIFO_READER_STATS_EN.
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int DATA_W     = fifo_reader_pkg::DATA_W,
  parameter int SKID_DEPTH = fifo_reader_pkg::SKID_DEPTH,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              burst_mode,
  input  logic              fifo_empty,
  input  logic              fifo_alm_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              rd_enb,
  output logic              dn_valid,
  output logic [DATA_W-1:0] dn_data,
  input  logic              dn_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  rd_count
);

  state_t     state;
  logic       inflight;
  logic       pop;
  logic [1:0] occ;
  logic [2:0] level;

  fifo_reader_skid #(
    .DW (DATA_W)
  ) u_skid (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight),
    .din   (fifo_data),
    .ready (dn_ready),
    .pop   (pop),
    .valid (dn_valid),
    .dout  (dn_data),
    .occ   (occ)
  );

  // Projected fill after this cycle's pop and pending capture.
  assign level = {1'b0, occ}
               + {2'b00, inflight}
               - {2'b00, pop};

  assign rd_enb = (state == STREAM)
                & enable
                & ~fifo_empty
                & (level < 3'(SKID_DEPTH));

  assign busy = (state != IDLE)
              | dn_valid
              | inflight;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      inflight <= 1'b0;
    end else begin
      inflight <= rd_enb;
      case (state)
        IDLE: begin
          if (enable) state <= WAIT;
        end
        WAIT: begin
          if (!enable)
            state <= IDLE;
          else if (!fifo_empty &&
                   (!burst_mode || !fifo_alm_empty))
            state <= STREAM;
        end
        STREAM: begin
          if (!enable || (fifo_empty && !rd_enb))
            state <= DRAIN;
        end
        DRAIN: begin
          if (occ == 2'd0 && !inflight)
            state <= enable ? WAIT : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FIFO_READER_STATS_EN
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt <= '0;
    else if (pop && cnt != '1)
      cnt <= cnt + 1'b1;
  end

  assign rd_count = cnt;
`else
  assign rd_count = '0;
`endif

endmodule
